// File: rtl/aes_pkg.sv
// Shared AES constants and byte-level helpers for the ShiftRows/MixColumns stage.
// Byte 0 of a state is bits [127:120]; bytes are column-major.
package aes_pkg;

    localparam int STATE_W = 128;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul2(input logic [7:0] b);
        return xtime(b);
    endfunction

    function automatic logic [7:0] gmul3(input logic [7:0] b);
        return xtime(b) ^ b;
    endfunction

    // out byte (r + 4c) takes in byte (r + 4((c + r) mod 4))
    function automatic logic [STATE_W-1:0] shift_rows(input logic [STATE_W-1:0] s);
        logic [STATE_W-1:0] o;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[127 - 8*(r + 4*c) -: 8] = s[127 - 8*(r + 4*((c + r) % 4)) -: 8];
            end
        end
        return o;
    endfunction

endpackage

// File: rtl/mix_column.sv
// MixColumns on a single 32-bit column; row 0 byte sits in bits [31:24].
module mix_column
    import aes_pkg::*;
(
    input  logic [31:0] i_col,
    output logic [31:0] o_col
);

    logic [7:0] w_a0, w_a1, w_a2, w_a3;

    assign w_a0 = i_col[31:24];
    assign w_a1 = i_col[23:16];
    assign w_a2 = i_col[15:8];
    assign w_a3 = i_col[7:0];

    assign o_col[31:24] = gmul2(w_a0) ^ gmul3(w_a1) ^ w_a2        ^ w_a3;
    assign o_col[23:16] = w_a0        ^ gmul2(w_a1) ^ gmul3(w_a2) ^ w_a3;
    assign o_col[15:8]  = w_a0        ^ w_a1        ^ gmul2(w_a2) ^ gmul3(w_a3);
    assign o_col[7:0]   = gmul3(w_a0) ^ w_a1        ^ w_a2        ^ gmul2(w_a3);

endmodule

// File: rtl/shift_mix.sv
// AES ShiftRows (+ MixColumns unless last round) with a registered result held in
// a two-entry main/skid buffer so in_ready never depends on out_ready.
module shift_mix
    import aes_pkg::*;
#(
    parameter int ROUND_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [STATE_W-1:0] s_in,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic [ROUND_W-1:0] in_round,
    output logic               in_ready,
    output logic [STATE_W-1:0] s_o,
    output logic [ROUND_W-1:0] out_round,
    output logic               out_valid,
    input  logic               out_ready
);

    logic [STATE_W-1:0] w_sr;
    logic [STATE_W-1:0] w_mc;
    logic [STATE_W-1:0] w_res;
    logic               w_push;
    logic               w_pop;
    logic [1:0]         w_occ_next;

    logic [STATE_W-1:0] r_main;
    logic [ROUND_W-1:0] r_main_round;
    logic [STATE_W-1:0] r_skid;
    logic [ROUND_W-1:0] r_skid_round;
    logic [1:0]         r_occ;
    logic               r_in_ready;

    assign w_sr = shift_rows(s_in);

    for (genvar c = 0; c < 4; c++) begin : g_col
        mix_column u_mix (
            .i_col (w_sr[127 - 32*c -: 32]),
            .o_col (w_mc[127 - 32*c -: 32])
        );
    end

    assign w_res  = in_last ? w_sr : w_mc;
    assign w_push = in_valid && r_in_ready;
    assign w_pop  = (r_occ != 2'd0) && out_ready;

    always_comb begin
        w_occ_next = r_occ;
        if (w_push && !w_pop) begin
            w_occ_next = r_occ + 2'd1;
        end else if (!w_push && w_pop) begin
            w_occ_next = r_occ - 2'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_main       <= '0;
            r_main_round <= '0;
            r_skid       <= '0;
            r_skid_round <= '0;
            r_occ        <= 2'd0;
            r_in_ready   <= 1'b0;
        end else begin
            // push cannot coincide with a full buffer: in_ready is low at occupancy 2
            if (r_occ == 2'd2) begin
                if (w_pop) begin
                    r_main       <= r_skid;
                    r_main_round <= r_skid_round;
                end
            end else if (w_push && (r_occ == 2'd0 || w_pop)) begin
                r_main       <= w_res;
                r_main_round <= in_round;
            end else if (w_push) begin
                r_skid       <= w_res;
                r_skid_round <= in_round;
            end
            r_occ      <= w_occ_next;
            r_in_ready <= (w_occ_next < 2'd2);
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = (r_occ != 2'd0);
    assign s_o       = r_main;
    assign out_round = r_main_round;

endmodule

// File: tb/tb_shift_mix.sv
// Self-checking bench for shift_mix: known-answer table, backpressure and reset
// sequences, then randomized traffic against a queue-based reference model.
module tb_shift_mix;

    localparam int RW = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [127:0]   s_in;
    logic           in_valid;
    logic           in_last;
    logic [RW-1:0]  in_round;
    logic           in_ready;
    logic [127:0]   s_o;
    logic [RW-1:0]  out_round;
    logic           out_valid;
    logic           out_ready;

    shift_mix #(.ROUND_W(RW)) dut (
        .clk       (clk),
        .rst       (rst),
        .s_in      (s_in),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_round  (in_round),
        .in_ready  (in_ready),
        .s_o       (s_o),
        .out_round (out_round),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [127:0] data;
        logic [RW-1:0] round;
    } beat_t;

    typedef struct {
        logic [127:0] s_in;
        logic         last;
        logic [127:0] exp;
    } vec_t;

    int     n_vec = 0;
    int     n_bad = 0;
    int     n_push = 0;
    beat_t  q[$];
    bit     exp_ready = 0;
    bit     just_rst = 0;

    function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1b) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [127:0] ref_model(input logic [127:0] s, input logic last);
        logic [7:0] b[16];
        logic [7:0] sr[16];
        logic [7:0] m[16];
        logic [7:0] coef[4][4];
        logic [127:0] o;
        coef = '{'{8'd2, 8'd3, 8'd1, 8'd1}, '{8'd1, 8'd2, 8'd3, 8'd1},
                 '{8'd1, 8'd1, 8'd2, 8'd3}, '{8'd3, 8'd1, 8'd1, 8'd2}};
        for (int k = 0; k < 16; k++) b[k] = s[127 - 8*k -: 8];
        for (int k = 0; k < 16; k++) sr[k] = b[(k % 4) + 4 * (((k / 4) + (k % 4)) % 4)];
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                m[4*c + r] = 8'h00;
                for (int j = 0; j < 4; j++) m[4*c + r] = m[4*c + r] ^ gf_mul(coef[r][j], sr[4*c + j]);
            end
        end
        o = '0;
        for (int k = 0; k < 16; k++) o[127 - 8*k -: 8] = last ? sr[k] : m[k];
        return o;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        chk("in_ready", {127'd0, in_ready}, {127'd0, exp_ready});
        chk("out_valid", {127'd0, out_valid}, {127'd0, q.size() != 0});
        if (q.size() != 0) begin
            chk("s_o", s_o, q[0].data);
            chk("out_round", {124'd0, out_round}, {124'd0, q[0].round});
        end
        if (just_rst) begin
            chk("rst_s_o", s_o, 128'h0);
            chk("rst_out_round", {124'd0, out_round}, 128'h0);
        end
    endtask

    // One clock: model advances on the same transfer rules, then DUT is compared.
    task automatic tick();
        bit    push, pop;
        beat_t nb;
        push = rst && in_valid && exp_ready;
        pop  = rst && (q.size() != 0) && out_ready;
        nb.data  = ref_model(s_in, in_last);
        nb.round = in_round;
        @(posedge clk);
        if (!rst) begin
            q.delete();
            exp_ready = 0;
            just_rst  = 1;
        end else begin
            just_rst = 0;
            if (pop) void'(q.pop_front());
            if (push) begin
                q.push_back(nb);
                n_push++;
            end
            exp_ready = (q.size() < 2);
        end
        #1;
        check_state();
    endtask

    vec_t vecs[4];
    int   seen[$];
    int   budget;

    initial begin
        rst = 0; s_in = '0; in_valid = 0; in_last = 0; in_round = '0; out_ready = 0;
        vecs[0] = '{128'h63cab7040953d051cd60e0e7ba70e18c, 1'b0, 128'h5f72641557f5bc92f7be3b291db9f91a};
        vecs[1] = '{128'h63cab7040953d051cd60e0e7ba70e18c, 1'b1, 128'h6353e08c0960e104cd70b751bacad0e7};
        vecs[2] = '{128'h00112233445566778899aabbccddeeff, 1'b1, 128'h0055aaff4499ee3388dd2277cc1166bb};
        vecs[3] = '{128'hd42711aee0bf98f1b8b45de51e415230, 1'b0, 128'h046681e5e0cb199a48f8d37a2806264c};

        tick(); tick();
        rst = 1;
        tick();

        // known-answer vectors, one per pass, downstream always ready
        for (int i = 0; i < 4; i++) begin
            s_in = vecs[i].s_in; in_last = vecs[i].last; in_round = RW'(i + 5);
            in_valid = 1; out_ready = 1;
            tick();
            in_valid = 0;
            chk("kat_valid", {127'd0, out_valid}, 128'd1);
            chk("kat_s_o", s_o, vecs[i].exp);
            tick();
        end

        // backpressure: rounds 1,2,3 with downstream stalled
        out_ready = 0; in_valid = 1; in_last = 0;
        for (int r = 1; r <= 3; r++) begin
            s_in = {$urandom, $urandom, $urandom, $urandom};
            in_round = RW'(r);
            tick();
        end
        chk("bp_ready_low", {127'd0, in_ready}, 128'd0);
        chk("bp_round_head", {124'd0, out_round}, 128'd1);
        out_ready = 1;
        budget = 0;
        while (seen.size() < 3 && budget < 20) begin
            if (out_valid) seen.push_back(int'(out_round));
            if (in_valid && in_ready) begin
                tick();
                in_valid = 0;
            end else begin
                tick();
            end
            budget++;
        end
        chk("bp_count", 128'(seen.size()), 128'd3);
        for (int i = 0; i < seen.size() && i < 3; i++) chk("bp_order", 128'(seen[i]), 128'(i + 1));

        // reset while full
        out_ready = 0; in_valid = 1;
        for (int r = 0; r < 2; r++) begin
            s_in = {$urandom, $urandom, $urandom, $urandom}; in_round = RW'(r + 9);
            tick();
        end
        chk("full_before_rst", {127'd0, in_ready}, 128'd0);
        rst = 0;
        tick();
        chk("rst_out_valid", {127'd0, out_valid}, 128'd0);
        rst = 1; in_valid = 0;
        tick();
        chk("rst_ready_back", {127'd0, in_ready}, 128'd1);

        // randomized traffic
        budget = 0;
        n_push = 0;
        while (n_push < 10000 && budget < 60000) begin
            s_in = {$urandom, $urandom, $urandom, $urandom};
            in_last = $urandom_range(0, 3) == 0;
            in_round = RW'($urandom);
            in_valid = $urandom_range(0, 3) != 0;
            out_ready = $urandom_range(0, 3) != 0;
            tick();
            budget++;
        end
        if (n_push < 10000) begin
            n_bad++;
            $display("FAIL random_budget: got %0d beats want 10000", n_push);
        end
        in_valid = 0; out_ready = 1;
        tick(); tick(); tick();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
